iterative_alu: RTL and testbench

- Execution-stage ALU that consumes the 4-bit ALUinput operation code from the ALU control decoder and produces the result.
- Logic and arithmetic ops complete in one cycle.
- Shifts (sll/srl/sra) run iteratively, one bit per cycle, to save area.
- Uses a start/busy/done handshake so the multi-cycle control FSM can stall while a shift is in progress.

---
 rtl/iterative_alu.sv | 158 +++++++++++++++
 tb/tb_iterative_alu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
//  Module   : iterative_alu
//  Purpose  : Execution-stage ALU; logic/arith ops in one cycle, shifts
//             iterate one bit per cycle behind a start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module iterative_alu #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUinput,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             illegal
);

   localparam int              c_SHW      = $clog2(WIDTH);
   localparam logic [c_SHW-1:0] c_CNT_ONE = 1;

   localparam logic [3:0] c_OP_AND  = 4'b0000;
   localparam logic [3:0] c_OP_OR   = 4'b0001;
   localparam logic [3:0] c_OP_ADD  = 4'b0010;
   localparam logic [3:0] c_OP_XOR  = 4'b0011;
   localparam logic [3:0] c_OP_SLL  = 4'b0100;
   localparam logic [3:0] c_OP_SRL  = 4'b0101;
   localparam logic [3:0] c_OP_SUB  = 4'b0110;
   localparam logic [3:0] c_OP_SLTU = 4'b0111;
   localparam logic [3:0] c_OP_SLT  = 4'b1000;
   localparam logic [3:0] c_OP_SRA  = 4'b1001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [3:0]         r_op;
   logic [WIDTH-1:0]   r_work;
   logic [c_SHW-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_illegal;

   logic [c_SHW-1:0]   w_shamt;
   logic               w_is_shift;
   logic               w_illegal;
   logic [WIDTH-1:0]   w_alu;
   logic [WIDTH-1:0]   w_step;

   assign w_shamt    = b[c_SHW-1:0];
   assign w_is_shift = (ALUinput == c_OP_SLL) || (ALUinput == c_OP_SRL) ||
                       (ALUinput == c_OP_SRA);

   // Shifts report operand a here so that a zero shift amount completes in one cycle.
   always_comb begin
      w_alu     = '0;
      w_illegal = 1'b0;
      case (ALUinput)
         c_OP_AND:  w_alu = a & b;
         c_OP_OR:   w_alu = a | b;
         c_OP_ADD:  w_alu = a + b;
         c_OP_XOR:  w_alu = a ^ b;
         c_OP_SUB:  w_alu = a - b;
         c_OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
         c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         c_OP_SLL, c_OP_SRL, c_OP_SRA: w_alu = a;
         default:   w_illegal = 1'b1;
      endcase
   end

   always_comb begin
      w_step = {1'b0, r_work[WIDTH-1:1]};
      if (r_op == c_OP_SLL) begin
         w_step = {r_work[WIDTH-2:0], 1'b0};
      end else if (r_op == c_OP_SRA) begin
         w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (w_is_shift && (w_shamt != '0)) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            if (r_cnt == c_CNT_ONE) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op      <= '0;
         r_work    <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_zero    <= 1'b1;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op <= ALUinput;
                  if (w_is_shift && (w_shamt != '0)) begin
                     r_work <= a;
                     r_cnt  <= w_shamt;
                  end else begin
                     r_result  <= w_alu;
                     r_zero    <= (w_alu == '0);
                     r_illegal <= w_illegal;
                  end
               end
            end
            S_SHIFT: begin
               r_work <= w_step;
               r_cnt  <= r_cnt - c_CNT_ONE;
               if (r_cnt == c_CNT_ONE) begin
                  r_result  <= w_step;
                  r_zero    <= (w_step == '0);
                  r_illegal <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign result  = r_result;
   assign zero    = r_zero;
   assign illegal = r_illegal;
   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iterative_alu
//  Purpose  : Self-checking bench: latency-level reference model plus
//             directed literal cases and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iterative_alu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  ALUinput = '0;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic [63:0] result;
   logic        zero, busy, done, illegal;

   int n_checks = 0;
   int n_fail   = 0;

   iterative_alu #(.WIDTH(64)) dut (
      .clk(clk), .reset(reset), .start(start), .ALUinput(ALUinput),
      .a(a), .b(b), .result(result), .zero(zero), .busy(busy),
      .done(done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain operators, and latency as a count of edges.
   task automatic ref_alu(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                          output logic [63:0] res, output logic ill, output int k);
      logic signed [63:0] sx;
      int sh;
      sx  = x;
      sh  = int'(y[5:0]);
      ill = 1'b0;
      k   = 1;
      res = '0;
      case (op)
         4'd0: res = x & y;
         4'd1: res = x | y;
         4'd2: res = x + y;
         4'd3: res = x ^ y;
         4'd4: begin res = x << sh;  k = sh + 1; end
         4'd5: begin res = x >> sh;  k = sh + 1; end
         4'd6: res = x - y;
         4'd7: res = (x < y) ? 64'd1 : 64'd0;
         4'd8: res = (sx < $signed(y)) ? 64'd1 : 64'd0;
         4'd9: begin res = sx >>> sh; k = sh + 1; end
         default: ill = 1'b1;
      endcase
   endtask

   logic        m_valid  = 1'b0;
   logic        m_indone = 1'b0;
   int          m_left   = 0;
   logic [63:0] m_res    = '0;
   logic        m_ill    = 1'b0;
   logic [63:0] p_res;
   logic        p_ill;
   int          p_k;

   always @(posedge clk) begin
      if (reset) begin
         m_valid = 1'b1; m_indone = 1'b0; m_left = 0; m_res = '0; m_ill = 1'b0;
      end else if (m_indone) begin
         m_indone = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_indone = 1'b1; m_res = p_res; m_ill = p_ill;
         end
      end else if (start) begin
         ref_alu(ALUinput, a, b, p_res, p_ill, p_k);
         m_left = p_k - 1;
         if (m_left == 0) begin
            m_indone = 1'b1; m_res = p_res; m_ill = p_ill;
         end
      end
      #1;
      if (m_valid) begin
         chk("model busy",    64'(busy),    64'(m_left > 0 || m_indone));
         chk("model done",    64'(done),    64'(m_indone));
         chk("model result",  result,       m_res);
         chk("model zero",    64'(zero),    64'(m_res == '0));
         chk("model illegal", 64'(illegal), 64'(m_ill));
      end
   end

   task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] exp, input int expk,
                         input logic expill, input bit poke);
      int k;
      @(negedge clk);
      start = 1'b1; ALUinput = op; a = x; b = y;
      @(negedge clk);
      start = 1'b0; k = 1;
      while (!done && k < 100) begin
         if (poke && k == 3) begin
            start = 1'b1; ALUinput = 4'd2; a = 64'h55; b = 64'h3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk({name, " latency"}, 64'(k), 64'(expk));
      chk({name, " result"}, result, exp);
      chk({name, " zero"}, 64'(zero), 64'(exp == '0));
      chk({name, " illegal"}, 64'(illegal), 64'(expill));
   endtask

   function automatic logic [63:0] rnd_val();
      case ($urandom_range(0, 5))
         0: rnd_val = '0;
         1: rnd_val = '1;
         2: rnd_val = 64'h8000_0000_0000_0000;
         3: rnd_val = 64'($urandom_range(0, 70));
         default: rnd_val = {$urandom(), $urandom()};
      endcase
   endfunction

   initial begin
      int dones;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset busy",    64'(busy),    64'd0);
      chk("reset done",    64'(done),    64'd0);
      chk("reset result",  result,       64'd0);
      chk("reset zero",    64'(zero),    64'd1);
      chk("reset illegal", 64'(illegal), 64'd0);

      run_op("add",       4'b0010, 64'd5, 64'd7, 64'd12, 1, 1'b0, 1'b0);
      run_op("sub eq",    4'b0110, 64'd3, 64'd3, 64'd0,  1, 1'b0, 1'b0);
      run_op("sub wrap",  4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, 1'b0);
      run_op("slt",       4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1, 1'b0, 1'b0);
      run_op("sltu",      4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 1'b0, 1'b0);
      run_op("sra",       4'b1001, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 5, 1'b0, 1'b0);
      run_op("srl",       4'b0101, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 5, 1'b0, 1'b0);
      run_op("sll 7",     4'b0100, 64'd1, 64'h47, 64'h80, 8, 1'b0, 1'b0);
      run_op("sll 0",     4'b0100, 64'h1234, 64'd0, 64'h1234, 1, 1'b0, 1'b0);
      run_op("sll 63",    4'b0100, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 64, 1'b0, 1'b0);
      run_op("sll poked", 4'b0100, 64'd3, 64'd10, 64'hC00, 11, 1'b0, 1'b1);
      run_op("illegal",   4'b1100, 64'd9, 64'd9, 64'd0, 1, 1'b1, 1'b0);
      run_op("add clr",   4'b0010, 64'd2, 64'd3, 64'd5, 1, 1'b0, 1'b0);

      // Reset in the middle of a long shift abandons it silently.
      @(negedge clk);
      start = 1'b1; ALUinput = 4'b0100; a = 64'd1; b = 64'd40;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("midreset busy",   64'(busy),   64'd0);
      chk("midreset done",   64'(done),   64'd0);
      chk("midreset result", result,      64'd0);
      chk("midreset zero",   64'(zero),   64'd1);
      dones = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("midreset no done", 64'(dones), 64'd0);

      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         reset    = ($urandom_range(0, 799) == 0);
         start    = ($urandom_range(0, 2) == 0);
         ALUinput = 4'($urandom_range(0, 15));
         a        = rnd_val();
         b        = rnd_val();
      end
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      repeat (80) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
